dff_bank_write_arbiter: RTL and testbench



---
 rtl/dff_bank_pkg.sv | 34 +++
 rtl/dff_bank_write_arbiter_rr_pick.sv | 41 ++++
 rtl/dff_bank_write_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_dff_bank_write_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Holds the arbiter state encoding, a constant clog2 helper and default sizes.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Ceiling log2, never below 1 so that index/address fields keep a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_bank_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
// Scans cand starting at ptr and wrapping modulo NREQ; reports the first set
// bit as a one-hot vector, its index, and whether anything was found.
module rr_pick
  import dff_bank_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0]  cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx,
  output logic             any
);

  // First candidate at or after ptr, wrapping around the requester ring.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!any && cand[idx]) begin
        any          = 1'b1;
        win[idx]     = 1'b1;
        win_idx      = PTR_W'(idx);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/dff_bank_write_arbiter.sv
// Round-robin arbiter sharing the single write port of a register bank.
// Grants one requester per cycle (registered, one-hot), drives bank write
// enable/address/data from the winner, and supports a lock that lets the
// owner write back-to-back. Out-of-range addresses still get a grant but
// raise wr_err instead of bank_we.
// Optional feature macro: ARB_COLL_CNT_EN adds a saturating 16-bit count of
// cycles with two or more competing candidates (port coll_cnt).
module dff_bank_write_arbiter
  import dff_bank_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    bank_we,
  output logic [ADDR_W-1:0]       bank_addr,
  output logic [WIDTH-1:0]        bank_wdata,
  output logic                    wr_err,
`ifdef ARB_COLL_CNT_EN
  output logic [15:0]             coll_cnt,
`endif
  output logic                    busy
);

  localparam int PTR_W = clog2(NREQ);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  arb_state_e        state_r, state_nxt_s;
  logic [PTR_W-1:0]  ptr_r, ptr_nxt_s;
  logic [PTR_W-1:0]  owner_r, owner_nxt_s;
  logic [NREQ-1:0]   gnt_r, gnt_nxt_s;
  logic              bank_we_r, wr_err_r, busy_r;
  logic [ADDR_W-1:0] bank_addr_r;
  logic [WIDTH-1:0]  bank_wdata_r;

  logic [NREQ-1:0]   cand_s, pick_cand_s;
  logic [PTR_W-1:0]  pick_ptr_s;
  logic [NREQ-1:0]   win_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic              any_s;
  logic              hold_s;
  logic              grant_s;
  logic [PTR_W-1:0]  sel_idx_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [WIDTH-1:0]  sel_wdata_s;
  logic              addr_ok_s;

  // Next index around the requester ring.
  function automatic logic [PTR_W-1:0] ring_next(input logic [PTR_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return '0;
    end else begin
      return idx + PTR_W'(1);
    end
  endfunction

  // Candidate set and picker inputs; a locked owner is never masked by its own grant.
  always_comb begin
    cand_s      = req & ~gnt_r;
    hold_s      = 1'b0;
    pick_cand_s = '0;
    pick_ptr_s  = ptr_r;
    if (state_r == LOCK) begin
      cand_s[owner_r]      = req[owner_r];
      hold_s               = req[owner_r] & lock[owner_r];
      pick_cand_s          = cand_s;
      pick_cand_s[owner_r] = 1'b0;
      pick_ptr_s           = ring_next(owner_r);
    end else begin
      pick_cand_s = cand_s;
      pick_ptr_s  = ptr_r;
    end
  end

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .cand    (pick_cand_s),
    .ptr     (pick_ptr_s),
    .win     (win_s),
    .win_idx (win_idx_s),
    .any     (any_s)
  );

  // Arbitration FSM: next state, pointer, owner and grant vector.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    owner_nxt_s = owner_r;
    gnt_nxt_s   = '0;
    sel_idx_s   = win_idx_s;
    case (state_r)
      IDLE, GRANT: begin
        if (any_s) begin
          gnt_nxt_s   = win_s;
          sel_idx_s   = win_idx_s;
          owner_nxt_s = win_idx_s;
          ptr_nxt_s   = ring_next(win_idx_s);
          state_nxt_s = lock[win_idx_s] ? LOCK : GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK: begin
        if (hold_s) begin
          gnt_nxt_s[owner_r] = 1'b1;
          sel_idx_s          = owner_r;
          state_nxt_s        = LOCK;
        end else if (any_s) begin
          gnt_nxt_s   = win_s;
          sel_idx_s   = win_idx_s;
          owner_nxt_s = win_idx_s;
          ptr_nxt_s   = ring_next(win_idx_s);
          state_nxt_s = lock[win_idx_s] ? LOCK : GRANT;
        end else begin
          ptr_nxt_s   = ring_next(owner_r);
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = '0;
        owner_nxt_s = '0;
      end
    endcase
  end

  // Winner's write fields and whether its address lands inside the bank.
  always_comb begin
    grant_s     = |gnt_nxt_s;
    sel_addr_s  = req_addr[int'(sel_idx_s)*ADDR_W +: ADDR_W];
    sel_wdata_s = req_wdata[int'(sel_idx_s)*WIDTH +: WIDTH];
    addr_ok_s   = ({1'b0, sel_addr_s} < DEPTH_L);
  end

  // Control state registers; reset drops any ownership and restarts at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      gnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      owner_r <= owner_nxt_s;
      gnt_r   <= gnt_nxt_s;
      busy_r  <= grant_s;
    end
  end

  // Bank write port; address/data hold their last values when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_we_r    <= 1'b0;
      wr_err_r     <= 1'b0;
      bank_addr_r  <= '0;
      bank_wdata_r <= '0;
    end else begin
      bank_we_r <= grant_s & addr_ok_s;
      wr_err_r  <= grant_s & ~addr_ok_s;
      if (grant_s) begin
        bank_addr_r  <= sel_addr_s;
        bank_wdata_r <= sel_wdata_s;
      end else begin
        bank_addr_r  <= bank_addr_r;
        bank_wdata_r <= bank_wdata_r;
      end
    end
  end

`ifdef ARB_COLL_CNT_EN
  logic [15:0] coll_cnt_r;
  logic        coll_s;

  // More than one candidate bit set (clearing the lowest set bit leaves something).
  always_comb begin
    coll_s = ((cand_s & (cand_s - NREQ'(1))) != '0);
  end

  // Saturating count of contended cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt_r <= 16'd0;
    end else if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
      coll_cnt_r <= coll_cnt_r + 16'd1;
    end else begin
      coll_cnt_r <= coll_cnt_r;
    end
  end

  assign coll_cnt = coll_cnt_r;
`endif

  assign gnt        = gnt_r;
  assign bank_we    = bank_we_r;
  assign bank_addr  = bank_addr_r;
  assign bank_wdata = bank_wdata_r;
  assign wr_err     = wr_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Directed bench for dff_bank_write_arbiter (NREQ=4, WIDTH=8, DEPTH=3).
// Inputs change 1ns after a rising edge; outputs are checked at that point,
// so each check sees the registers loaded by the edge just taken.
module tb_dff_bank_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic        bank_we;
  logic [1:0]  bank_addr;
  logic [7:0]  bank_wdata;
  logic        wr_err;
  logic        busy;
`ifdef ARB_COLL_CNT_EN
  logic [15:0] coll_cnt;
`endif

  int n_checks;
  int n_pass;

  dff_bank_write_arbiter #(
    .NREQ   (4),
    .WIDTH  (8),
    .DEPTH  (3),
    .ADDR_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .wr_err     (wr_err),
`ifdef ARB_COLL_CNT_EN
    .coll_cnt   (coll_cnt),
`endif
    .busy       (busy)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req       = 4'b1111;
    lock      = 4'b0000;
    req_addr  = {2'd2, 2'd2, 2'd1, 2'd0};
    req_wdata = {8'h13, 8'h12, 8'h11, 8'h10};

    // 1: reset beats requests
    tick();
    check("rst1_gnt", gnt, 4'b0000);
    check("rst1_we", bank_we, 1'b0);
    check("rst1_busy", busy, 1'b0);
    check("rst1_err", wr_err, 1'b0);
    check("rst1_addr", bank_addr, 2'd0);
    check("rst1_data", bank_wdata, 8'h00);
    tick();
    check("rst2_gnt", gnt, 4'b0000);
    rst = 1'b0;

    // 2: all four held, round robin 0,1,2,3,0
    tick();
    check("rr0_gnt", gnt, 4'b0001);
    check("rr0_we", bank_we, 1'b1);
    check("rr0_data", bank_wdata, 8'h10);
    check("rr0_busy", busy, 1'b1);
    tick();
    check("rr1_gnt", gnt, 4'b0010);
    check("rr1_addr", bank_addr, 2'd1);
    check("rr1_data", bank_wdata, 8'h11);
    tick();
    check("rr2_gnt", gnt, 4'b0100);
    tick();
    check("rr3_gnt", gnt, 4'b1000);
    check("rr3_addr", bank_addr, 2'd2);
    check("rr3_data", bank_wdata, 8'h13);
    check("rr3_we", bank_we, 1'b1);
    tick();
    check("rr4_gnt", gnt, 4'b0001);

    // 3: sole requester 1 held -> grant every other cycle
    req       = 4'b0010;
    req_addr[3:2]   = 2'd2;
    req_wdata[15:8] = 8'hA5;
    tick();
    check("solo0_gnt", gnt, 4'b0010);
    check("solo0_we", bank_we, 1'b1);
    check("solo0_addr", bank_addr, 2'd2);
    check("solo0_data", bank_wdata, 8'hA5);
    tick();
    check("solo1_gnt", gnt, 4'b0000);
    check("solo1_we", bank_we, 1'b0);
    check("solo1_busy", busy, 1'b0);
    check("solo1_addr", bank_addr, 2'd2);
    tick();
    check("solo2_gnt", gnt, 4'b0010);
    check("solo2_we", bank_we, 1'b1);
    tick();
    check("solo3_gnt", gnt, 4'b0000);
    req = 4'b0000;

    // 4: lock by requester 0 with requester 2 pending (start from ptr=0)
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b0101;
    lock = 4'b0001;
    tick();
    check("lk0_gnt", gnt, 4'b0001);
    tick();
    check("lk1_gnt", gnt, 4'b0001);
    check("lk1_we", bank_we, 1'b1);
    tick();
    check("lk2_gnt", gnt, 4'b0001);
    req  = 4'b0100;
    lock = 4'b0000;
    tick();
    check("lk_rel_gnt", gnt, 4'b0100);
    check("lk_rel_data", bank_wdata, 8'h12);
    // ptr must now be 3: requester 3 beats 0 and 1
    req = 4'b1011;
    tick();
    check("ptr3_gnt", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("idle_gnt", gnt, 4'b0000);

    // 5: out-of-range address (3 >= DEPTH)
    req_addr[7:6] = 2'd3;
    req = 4'b1000;
    tick();
    check("oor_gnt", gnt, 4'b1000);
    check("oor_we", bank_we, 1'b0);
    check("oor_err", wr_err, 1'b1);
    check("oor_busy", busy, 1'b1);
    req = 4'b0000;
    tick();
    check("oor_after_gnt", gnt, 4'b0000);
    check("oor_after_err", wr_err, 1'b0);

    // 6: reset during lock drops ownership and restarts from requester 0
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    check("rl0_gnt", gnt, 4'b0010);
    tick();
    check("rl1_gnt", gnt, 4'b0010);
    rst = 1'b1;
    tick();
    check("rl_rst_gnt", gnt, 4'b0000);
    check("rl_rst_we", bank_we, 1'b0);
    check("rl_rst_busy", busy, 1'b0);
`ifdef ARB_COLL_CNT_EN
    check("rl_rst_coll", coll_cnt, 16'd0);
`endif
    rst  = 1'b0;
    req  = 4'b1111;
    lock = 4'b0000;
    tick();
    check("rl_after_gnt", gnt, 4'b0001);
`ifdef ARB_COLL_CNT_EN
    check("rl_after_coll", coll_cnt, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
